// File: rtl/wb_rr_arbiter_if.sv
// Bus bundle for wb_rr_arbiter: N Wishbone master ports plus one pipelined slave port.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface wb_rr_arbiter_if #(
  parameter int N_MASTERS = 2,
  parameter int AXI_WIDTH = 32,
  parameter int AXI_DEPTH = 32
);
  logic [N_MASTERS-1:0]           m_cyc_i;
  logic [N_MASTERS-1:0]           m_stb_i;
  logic [N_MASTERS-1:0]           m_we_i;
  logic [N_MASTERS*AXI_DEPTH-1:0] m_addr_i;
  logic [N_MASTERS*AXI_WIDTH-1:0] m_data_i;
  logic [N_MASTERS-1:0]           m_stall_o;
  logic [N_MASTERS-1:0]           m_ack_o;
  logic [N_MASTERS-1:0]           m_err_o;
  logic [AXI_WIDTH-1:0]           m_data_o;
  logic                           s_cyc_o;
  logic                           s_stb_o;
  logic                           s_we_o;
  logic [AXI_DEPTH-1:0]           s_addr_o;
  logic [AXI_WIDTH-1:0]           s_data_o;
  logic                           s_stall_i;
  logic                           s_ack_i;
  logic [AXI_WIDTH-1:0]           s_data_i;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_data_i, s_stall_i, s_ack_i, s_data_i,
    output m_stall_o, m_ack_o, m_err_o, m_data_o, s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_data_i, s_stall_i, s_ack_i, s_data_i,
    input  m_stall_o, m_ack_o, m_err_o, m_data_o, s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone slave between N masters, with an
// outstanding-strobe throttle. Define WB_RR_ARBITER_TIMEOUT_EN to add the ack watchdog.
module wb_rr_arbiter #(
  parameter int N_MASTERS       = 2,
  parameter int AXI_WIDTH       = 32,
  parameter int AXI_DEPTH       = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input logic            wb_clk_i,
  input logic            wb_rst_i,
  wb_rr_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(N_MASTERS);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  if (N_MASTERS < 2 || N_MASTERS > 8 || MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 16 ||
      (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("wb_rr_arbiter: illegal parameter combination");
  end

  typedef enum logic {IDLE, OWNED} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d, ptr_q, ptr_d, pick, cand, grant_next;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  logic             owned, full, empty, accept, ack_fwd, timeout;
  int               sel;

  assign owned      = (state_q == OWNED);
  assign full       = (outstanding_q == OUT_W'(MAX_OUTSTANDING));
  assign empty      = (outstanding_q == '0);
  assign grant_next = (grant_q == IDX_W'(N_MASTERS - 1)) ? '0 : grant_q + IDX_W'(1);

  // NOTE: every output gets a default before the branches, so no path can infer a latch.
  always_comb begin
    bus.s_cyc_o   = 1'b0;
    bus.s_stb_o   = 1'b0;
    bus.s_we_o    = 1'b0;
    bus.s_addr_o  = '0;
    bus.s_data_o  = '0;
    bus.m_stall_o = '1;
    bus.m_ack_o   = '0;
    bus.m_data_o  = '0;
    if (owned) begin
      bus.m_data_o = bus.s_data_i;
      for (int k = 0; k < N_MASTERS; k++) begin
        if (grant_q == IDX_W'(k)) begin
          bus.s_cyc_o      = bus.m_cyc_i[k];
          bus.s_stb_o      = bus.m_stb_i[k] && !full;
          bus.s_we_o       = bus.m_we_i[k];
          bus.s_addr_o     = bus.m_addr_i[k*AXI_DEPTH +: AXI_DEPTH];
          bus.s_data_o     = bus.m_data_i[k*AXI_WIDTH +: AXI_WIDTH];
          bus.m_stall_o[k] = bus.s_stall_i || full;
          bus.m_ack_o[k]   = bus.s_ack_i && !empty;
        end
      end
    end
  end

  assign accept  = bus.s_stb_o && !bus.s_stall_i;
  assign ack_fwd = |bus.m_ack_o;

  // First requester at or after the rotation pointer, wrapping.
  always_comb begin
    pick  = ptr_q;
    sel   = 0;
    cand  = '0;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      sel = int'(ptr_q) + i;
      if (sel >= N_MASTERS) sel = sel - N_MASTERS;
      cand = IDX_W'(sel);
      if (bus.m_cyc_i[cand]) pick = cand;
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    ptr_d         = ptr_q;
    outstanding_d = outstanding_q;
    case (state_q)
      IDLE: begin
        if (|bus.m_cyc_i) begin
          state_d = OWNED;
          grant_d = pick;
        end
      end
      OWNED: begin
        // Dropping cyc aborts the cycle: unacked strobes are forgotten.
        if (!bus.s_cyc_o || timeout) begin
          state_d       = IDLE;
          ptr_d         = grant_next;
          outstanding_d = '0;
        end else if (accept && !ack_fwd) begin
          outstanding_d = outstanding_q + OUT_W'(1);
        end else if (!accept && ack_fwd) begin
          outstanding_d = outstanding_q - OUT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with <= only, so every flop samples pre-edge values.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      ptr_q         <= '0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      ptr_q         <= ptr_d;
      outstanding_q <= outstanding_d;
    end
  end

`ifdef WB_RR_ARBITER_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [N_MASTERS-1:0] err_q, err_d;

  // Counts only idle-waiting cycles; any bus progress restarts the watchdog.
  always_comb begin
    timer_d = '0;
    err_d   = '0;
    timeout = 1'b0;
    if (owned && bus.s_cyc_o && !accept && !ack_fwd && !empty) begin
      if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
        timeout = 1'b1;
        err_d   = N_MASTERS'(1) << grant_q;
      end else begin
        timer_d = timer_q + TMR_W'(1);
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      timer_q <= '0;
      err_q   <= '0;
    end else begin
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  assign bus.m_err_o = err_q;
`else
  assign timeout     = 1'b0;
  assign bus.m_err_o = '0;
`endif
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model of the arbiter.
module tb_wb_rr_arbiter;
  localparam int N    = 2;
  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int MAXO = 4;
  localparam int TMO  = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   acc_cnt;

  // Model state: owner index (-1 = bus free), rotation pointer, unacked strobes,
  // watchdog count, and the master that gets an error pulse this cycle (-1 = none).
  int m_own = -1;
  int m_ptr = 0;
  int m_outs = 0;
  int m_tmr = 0;
  int m_err = -1;
  bit m_acc, m_fwd, m_timed;

  logic          e_cyc, e_stb, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_rdata;
  logic [N-1:0]  e_stall, e_ack, e_err;

  wb_rr_arbiter_if #(.N_MASTERS(N), .AXI_WIDTH(DW), .AXI_DEPTH(AW)) bus ();

  wb_rr_arbiter #(
    .N_MASTERS(N), .AXI_WIDTH(DW), .AXI_DEPTH(AW),
    .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model advance: what the arbiter must remember after each edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_own = -1; m_ptr = 0; m_outs = 0; m_tmr = 0; m_err = -1;
    end else begin
      m_err = -1;
      if (m_own < 0) begin
        for (int i = 0; i < N; i++)
          if (m_own < 0 && bus.m_cyc_i[(m_ptr + i) % N]) m_own = (m_ptr + i) % N;
        m_outs = 0;
        m_tmr  = 0;
      end else begin
        m_acc   = bus.m_stb_i[m_own] && (m_outs != MAXO) && !bus.s_stall_i;
        m_fwd   = bus.s_ack_i && (m_outs != 0);
        m_timed = 1'b0;
`ifdef WB_RR_ARBITER_TIMEOUT_EN
        if (m_acc || m_fwd || m_outs == 0) m_tmr = 0;
        else begin
          m_tmr++;
          m_timed = (m_tmr == TMO) && bus.m_cyc_i[m_own];
        end
`endif
        if (!bus.m_cyc_i[m_own] || m_timed) begin
          if (m_timed) m_err = m_own;
          m_ptr  = (m_own + 1) % N;
          m_own  = -1;
          m_outs = 0;
          m_tmr  = 0;
        end else begin
          m_outs = m_outs + int'(m_acc) - int'(m_fwd);
        end
      end
    end
  end

  // Per-cycle compare, mid-cycle, against outputs derived from the model state.
  always @(negedge clk) begin
    e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
    e_stall = '1; e_ack = '0; e_rdata = '0; e_err = '0;
    if (m_own >= 0) begin
      e_cyc            = bus.m_cyc_i[m_own];
      e_stb            = bus.m_stb_i[m_own] && (m_outs != MAXO);
      e_we             = bus.m_we_i[m_own];
      e_addr           = bus.m_addr_i[m_own*AW +: AW];
      e_wdata          = bus.m_data_i[m_own*DW +: DW];
      e_stall[m_own]   = bus.s_stall_i || (m_outs == MAXO);
      e_ack[m_own]     = bus.s_ack_i && (m_outs != 0);
      e_rdata          = bus.s_data_i;
    end
    if (m_err >= 0) e_err[m_err] = 1'b1;
    check("s_cyc_o", bus.s_cyc_o, e_cyc);
    check("s_stb_o", bus.s_stb_o, e_stb);
    check("s_we_o", bus.s_we_o, e_we);
    check("s_addr_o", bus.s_addr_o, e_addr);
    check("s_data_o", bus.s_data_o, e_wdata);
    check("m_stall_o", bus.m_stall_o, e_stall);
    check("m_ack_o", bus.m_ack_o, e_ack);
    check("m_err_o", bus.m_err_o, e_err);
    check("m_data_o", bus.m_data_o, e_rdata);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    bus.m_cyc_i = '0; bus.m_stb_i = '0; bus.m_we_i = '0;
    bus.m_addr_i = '0; bus.m_data_i = '0;
    bus.s_stall_i = 1'b0; bus.s_ack_i = 1'b0; bus.s_data_i = '0;
  endtask

  task automatic set_m(input int k, input bit cyc, input bit stb, input bit we,
                       input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bus.m_cyc_i[k] = cyc;
    bus.m_stb_i[k] = stb;
    bus.m_we_i[k]  = we;
    bus.m_addr_i[k*AW +: AW] = addr;
    bus.m_data_i[k*DW +: DW] = data;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    clear_inputs();
    #1 rst = 1'b1;
    #2;
    check("reset s_cyc_o", bus.s_cyc_o, 1'b0);
    check("reset m_stall_o", bus.m_stall_o, 2'b11);
    check("reset m_ack_o", bus.m_ack_o, 2'b00);
    check("reset m_err_o", bus.m_err_o, 2'b00);
    check("reset m_data_o", bus.m_data_o, 32'h0);
    do_reset();

    // Single master write with a delayed ack.
    set_m(0, 1, 1, 1, 32'h10, 32'hA5A5_0001);
    settle();
    check("single grant latency", bus.s_cyc_o, 1'b0);
    tick(); settle();
    check("single s_cyc_o", bus.s_cyc_o, 1'b1);
    check("single s_addr_o", bus.s_addr_o, 32'h10);
    check("single s_data_o", bus.s_data_o, 32'hA5A5_0001);
    check("single s_stall", bus.m_stall_o, 2'b10);
    tick(); bus.m_stb_i[0] = 1'b0; settle();
    check("single stb drop", bus.s_stb_o, 1'b0);
    tick(); bus.s_ack_i = 1'b1; bus.s_data_i = 32'h1234_5678; settle();
    check("single ack", bus.m_ack_o, 2'b01);
    check("single rdata", bus.m_data_o, 32'h1234_5678);
    tick(); bus.s_ack_i = 1'b0; settle();
    check("single ack one cycle", bus.m_ack_o, 2'b00);
    tick(); bus.s_ack_i = 1'b1; settle();
    check("single outstanding back to 0", bus.m_ack_o, 2'b00);
    tick(); clear_inputs(); tick();

    // Contention and rotation.
    do_reset();
    set_m(0, 1, 0, 0, 32'h100, 0); set_m(1, 1, 0, 0, 32'h200, 0);
    tick(); settle();
    check("contend m0 first", bus.m_stall_o, 2'b10);
    check("contend addr", bus.s_addr_o, 32'h100);
    tick(); bus.m_cyc_i[0] = 1'b0; settle();
    check("contend release", bus.s_cyc_o, 1'b0);
    tick(); bus.m_cyc_i[0] = 1'b1; settle();
    check("contend idle gap", bus.m_stall_o, 2'b11);
    tick(); settle();
    check("contend m1 next", bus.m_stall_o, 2'b01);
    check("contend m1 addr", bus.s_addr_o, 32'h200);
    clear_inputs(); tick(); tick();

    // Throttle at MAX_OUTSTANDING with a silent slave.
    do_reset();
    set_m(0, 1, 1, 1, 32'h40, 32'hBEEF);
    acc_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick(); settle();
      if (bus.s_stb_o && !bus.s_stall_i) acc_cnt++;
      if (i >= 4) begin
        check("throttle stall", bus.m_stall_o[0], 1'b1);
        check("throttle stb", bus.s_stb_o, 1'b0);
      end
    end
    check("throttle accepted", acc_cnt, 4);
    tick(); bus.s_ack_i = 1'b1; settle();
    check("throttle ack fwd", bus.m_ack_o, 2'b01);
    tick(); bus.s_ack_i = 1'b0; settle();
    check("throttle 5th stb", bus.s_stb_o, 1'b1);
    check("throttle unstall", bus.m_stall_o[0], 1'b0);
    clear_inputs(); tick(); tick();

    // Abort with two strobes outstanding.
    do_reset();
    set_m(1, 1, 1, 0, 32'h80, 0);
    tick(); tick();
    tick(); bus.m_cyc_i[1] = 1'b0; bus.m_stb_i[1] = 1'b0; settle();
    check("abort cyc drop", bus.s_cyc_o, 1'b0);
    tick(); bus.s_ack_i = 1'b1; settle();
    check("abort late ack idle", bus.m_ack_o, 2'b00);
    tick(); bus.m_cyc_i[1] = 1'b1; settle();
    check("abort late ack 2", bus.m_ack_o, 2'b00);
    tick(); settle();
    check("abort regrant", bus.s_cyc_o, 1'b1);
    check("abort outstanding cleared", bus.m_ack_o, 2'b00);
    clear_inputs(); tick(); tick();

    // Asynchronous reset mid-burst, then pointer back to m0.
    do_reset();
    set_m(0, 1, 0, 0, 0, 0);
    tick(); bus.m_cyc_i[0] = 1'b0;
    tick(); set_m(1, 1, 1, 1, 32'hC0, 32'h77);
    tick(); tick();
    #1 rst = 1'b1;
    #1;
    check("rst async s_cyc_o", bus.s_cyc_o, 1'b0);
    check("rst async stall", bus.m_stall_o, 2'b11);
    check("rst async s_stb_o", bus.s_stb_o, 1'b0);
    tick(); rst = 1'b0;
    bus.m_cyc_i = 2'b11; bus.m_stb_i = 2'b00;
    tick(); settle();
    check("rst first grant m0", bus.m_stall_o, 2'b10);
    clear_inputs(); tick(); tick();

`ifdef WB_RR_ARBITER_TIMEOUT_EN
    // Watchdog: one accepted strobe, never acked.
    do_reset();
    set_m(0, 1, 1, 0, 32'h20, 0);
    tick();
    tick(); bus.m_stb_i[0] = 1'b0; bus.m_cyc_i[1] = 1'b1;
    for (int i = 0; i < TMO; i++) begin
      settle();
      check("timeout no early err", bus.m_err_o, 2'b00);
      tick();
    end
    settle();
    check("timeout err pulse", bus.m_err_o, 2'b01);
    check("timeout bus released", bus.s_cyc_o, 1'b0);
    tick(); settle();
    check("timeout err one cycle", bus.m_err_o, 2'b00);
    check("timeout m1 granted", bus.m_stall_o, 2'b01);
    clear_inputs(); tick(); tick();
`endif

    // Randomized traffic; the negedge compare does the checking.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(7) == 0) bus.m_cyc_i[k] = !bus.m_cyc_i[k];
        bus.m_stb_i[k] = bus.m_cyc_i[k] && ($urandom_range(1) == 1);
        bus.m_we_i[k]  = 1'($urandom_range(1));
        bus.m_addr_i[k*AW +: AW] = $urandom;
        bus.m_data_i[k*DW +: DW] = $urandom;
      end
      bus.s_stall_i = ($urandom_range(3) == 0);
      bus.s_ack_i   = ($urandom_range(2) == 0);
      bus.s_data_i  = $urandom;
      if (c == 1500) begin
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
      end
      tick();
    end

    clear_inputs();
    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
